// File: rtl/reg_dump_pkg.sv
// Shared types and widths for the register dump engine.
// REG_DUMP_CSUM_EN adds the checksum state to the state type.
package reg_dump_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;

`ifdef REG_DUMP_CSUM_EN
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StCsum,
        StDone
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StDone
    } state_e;
`endif

endpackage

// File: rtl/reg_dump_csum.sv
// XOR accumulator over the dumped register values.
// Instantiated by reg_dump only when REG_DUMP_CSUM_EN is defined.
module reg_dump_csum
    import reg_dump_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              update,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (update) begin
            acc_q <= acc_q ^ din;
        end
    end

    assign value = acc_q;

endmodule

// File: rtl/reg_dump.sv
// Debug register dump: walks the register file through one read port and streams
// each value over valid/ready. Optional trailing checksum beat: REG_DUMP_CSUM_EN.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 busy,
    output logic                 hold_wr,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [DATA_W-1:0]    dump_data,
    output logic [REG_IDX_W-1:0] dump_idx,
    output logic                 dump_last,
    output logic                 done
);

    localparam logic [REG_IDX_W-1:0] LastIdx = REG_IDX_W'(NUM_REGS - 1);

    state_e               state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [REG_IDX_W-1:0] didx_q, didx_d;

`ifdef REG_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum_value;

    reg_dump_csum u_csum (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == StIdle && start),
        .update (state_q == StSend && dump_ready),
        .din    (data_q),
        .value  (csum_value)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
            didx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        didx_d  = didx_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                data_d  = rd_data;
                didx_d  = idx_q;
                state_d = StSend;
            end
            StSend: begin
                if (dump_ready) begin
                    if (idx_q == LastIdx) begin
`ifdef REG_DUMP_CSUM_EN
                        // Accumulator lags one beat; fold in the beat being accepted now.
                        data_d  = csum_value ^ data_q;
                        didx_d  = '1;
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
`ifdef REG_DUMP_CSUM_EN
            StCsum: begin
                if (dump_ready) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rd_addr    = (state_q == StFetch) ? ADDR_W'(idx_q) : '0;
    assign busy       = (state_q != StIdle);
    assign hold_wr    = busy;
    assign dump_data  = data_q;
    assign dump_idx   = didx_q;
    assign done       = (state_q == StDone);

`ifdef REG_DUMP_CSUM_EN
    assign dump_valid = (state_q == StSend) || (state_q == StCsum);
    assign dump_last  = (state_q == StCsum);
`else
    assign dump_valid = (state_q == StSend);
    assign dump_last  = (state_q == StSend) && (idx_q == LastIdx);
`endif

endmodule
